// File: rtl/misere_pkg.sv
// Shared encodings and the scan direction table for the misere board engine.
package misere_pkg;

  // Cell contents
  localparam logic [1:0] SYM_EMPTY = 2'b00;
  localparam logic [1:0] SYM_X     = 2'b01;
  localparam logic [1:0] SYM_O     = 2'b10;

  // Game result codes
  localparam logic [1:0] RES_PLAY  = 2'b00;
  localparam logic [1:0] RES_P1    = 2'b01;
  localparam logic [1:0] RES_P2    = 2'b10;
  localparam logic [1:0] RES_TIE   = 2'b11;

  // Whose move it is
  localparam logic [1:0] TURN_P1   = 2'b01;
  localparam logic [1:0] TURN_P2   = 2'b10;

  // Control states of the engine
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_SCAN  = 3'd2,
    S_DONE  = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  // Row step per direction: horizontal, vertical, diagonal, anti-diagonal
  function automatic logic signed [1:0] dir_dr(input logic [1:0] d);
    case (d)
      2'd0:    return 2'sb00;
      2'd1:    return 2'sb01;
      2'd2:    return 2'sb01;
      2'd3:    return 2'sb01;
      default: return 2'sb00;
    endcase
  endfunction

  // Column step per direction: horizontal, vertical, diagonal, anti-diagonal
  function automatic logic signed [1:0] dir_dc(input logic [1:0] d);
    case (d)
      2'd0:    return 2'sb01;
      2'd1:    return 2'sb00;
      2'd2:    return 2'sb01;
      2'd3:    return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/line_walker.sv
// Sequential line scanner: visits the K-1 cells on each side of the last
// placed cell in four directions, one cell per cycle, and flags a losing run.
module line_walker
  import misere_pkg::*;
#(
  parameter int N     = 3,
  parameter int K     = 3,
  parameter int IDX_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             active_i,
  input  logic [2:0]       row_i,
  input  logic [2:0]       col_i,
  input  logic [1:0]       sym_i,
  input  logic [1:0]       cell_i,
  output logic [IDX_W-1:0] probe_idx_o,
  output logic             probe_on_o,
  output logic             lose_o,
  output logic             scan_done_o
);

  logic [1:0] dir_q;
  logic       side_q;      // 0 = negative side, 1 = positive side
  logic [2:0] dist_q;      // 1..K-1 cells away from the placed cell
  logic       flag_q;      // current side still unbroken
  logic [3:0] run_q;
  logic       lose_q;

  logic signed [1:0] dr_s, dc_s;
  logic signed [5:0] dr6_s, dc6_s, dist6_s, off_r_s, off_c_s, pr_s, pc_s;
  logic              on_s, flag_eff_s, hit_s, last_side_s;
  logic [3:0]        run_nx_s;

  // Probe coordinate for the current step and its on-board test
  always_comb begin
    dr_s    = dir_dr(dir_q);
    dc_s    = dir_dc(dir_q);
    dr6_s   = {{4{dr_s[1]}}, dr_s};
    dc6_s   = {{4{dc_s[1]}}, dc_s};
    dist6_s = signed'({3'b000, dist_q});
    if (side_q) begin
      off_r_s = dr6_s * dist6_s;
      off_c_s = dc6_s * dist6_s;
    end else begin
      off_r_s = -(dr6_s * dist6_s);
      off_c_s = -(dc6_s * dist6_s);
    end
    pr_s = signed'({3'b000, row_i}) + off_r_s;
    pc_s = signed'({3'b000, col_i}) + off_c_s;
    // Bounds are checked per axis so a column overflow never wraps into the next row
    on_s = !pr_s[5] && (pr_s[4:0] < 5'(N)) && !pc_s[5] && (pc_s[4:0] < 5'(N));
    if (on_s) begin
      probe_idx_o = IDX_W'(pr_s[2:0]) * IDX_W'(N) + IDX_W'(pc_s[2:0]);
    end else begin
      probe_idx_o = '0;
    end
    probe_on_o = on_s;
  end

  // Match accumulation for the current step
  always_comb begin
    flag_eff_s  = (dist_q == 3'd1) ? 1'b1 : flag_q;
    hit_s       = on_s && (cell_i == sym_i) && flag_eff_s;
    run_nx_s    = run_q + (hit_s ? 4'd1 : 4'd0);
    last_side_s = (dist_q == 3'(K - 1));
    scan_done_o = active_i && last_side_s && side_q && (dir_q == 2'd3);
  end

  // Step, side and direction sequencing plus run/lose bookkeeping
  always_ff @(posedge clock) begin
    if (!resetn || start_i) begin
      dir_q  <= 2'd0;
      side_q <= 1'b0;
      dist_q <= 3'd1;
      flag_q <= 1'b1;
      run_q  <= 4'd1;
      lose_q <= 1'b0;
    end else if (active_i) begin
      flag_q <= hit_s;
      if (last_side_s) begin
        dist_q <= 3'd1;
        side_q <= ~side_q;
        if (side_q) begin
          dir_q <= dir_q + 2'd1;
          run_q <= 4'd1;
          if (run_nx_s >= 4'(K)) begin
            lose_q <= 1'b1;
          end
        end else begin
          run_q <= run_nx_s;
        end
      end else begin
        dist_q <= dist_q + 3'd1;
        run_q  <= run_nx_s;
      end
    end
  end

  assign lose_o = lose_q;

endmodule

// File: rtl/misere_board_engine.sv
// N x N K-in-a-row Wild Misere core: board storage, move validation,
// turn tracking and a sequenced end-of-game scan around the last move.
module misere_board_engine
  import misere_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int K     = 3,
  localparam int POS_W = $clog2(N*N+1),
  localparam int CNT_W = $clog2(N*N+1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             new_game,
  input  logic             mv_valid,
  output logic             mv_ready,
  input  logic [POS_W-1:0] mv_pos,
  input  logic [1:0]       mv_sym,
  output logic             mv_err,
  output logic             res_valid,
  output logic             game_over,
  output logic [1:0]       result,
  output logic [1:0]       turn,
  input  logic [POS_W-1:0] rd_pos,
  output logic [1:0]       rd_sym,
  output logic [CNT_W-1:0] fill_cnt
);

  localparam int CELLS = N * N;
  localparam int IDX_W = $clog2(CELLS);

  state_e           state_q, state_d;
  logic [1:0]       board_q [CELLS];
  logic [2:0]       row_q, row_d, col_q, col_d;
  logic [1:0]       sym_q, sym_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [1:0]       turn_q, turn_d, result_q, result_d;
  logic             game_over_q, game_over_d;
  logic             mv_err_q, mv_err_d, res_valid_q, res_valid_d;

  logic             clear_s, write_s, start_s, active_s;
  logic             pos_ok_s, sym_ok_s, legal_s, rd_ok_s;
  logic [IDX_W-1:0] mv_idx_s, wr_idx_s, probe_idx_s;
  logic [1:0]       target_s, probe_cell_s;
  logic             probe_on_s, lose_s, scan_done_s;

  // Move validation and board read ports
  always_comb begin
    pos_ok_s = (mv_pos != '0) && (mv_pos <= POS_W'(CELLS));
    sym_ok_s = (mv_sym == SYM_X) || (mv_sym == SYM_O);
    mv_idx_s = IDX_W'(mv_pos - POS_W'(1));
    if (pos_ok_s) begin
      target_s = board_q[mv_idx_s];
    end else begin
      target_s = SYM_EMPTY;
    end
    legal_s  = pos_ok_s && sym_ok_s && (target_s == SYM_EMPTY);
    wr_idx_s = IDX_W'(row_q) * IDX_W'(N) + IDX_W'(col_q);
    rd_ok_s  = (rd_pos != '0) && (rd_pos <= POS_W'(CELLS));
    if (rd_ok_s) begin
      rd_sym = board_q[IDX_W'(rd_pos - POS_W'(1))];
    end else begin
      rd_sym = SYM_EMPTY;
    end
    if (probe_on_s) begin
      probe_cell_s = board_q[probe_idx_s];
    end else begin
      probe_cell_s = SYM_EMPTY;
    end
  end

  // Next-state and output decode of the game controller
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    sym_d       = sym_q;
    fill_d      = fill_q;
    turn_d      = turn_q;
    result_d    = result_q;
    game_over_d = game_over_q;
    mv_err_d    = 1'b0;
    res_valid_d = 1'b0;
    clear_s     = 1'b0;
    write_s     = 1'b0;
    start_s     = 1'b0;
    active_s    = (state_q == S_SCAN);
    case (state_q)
      S_IDLE: begin
        if (new_game) begin
          clear_s = 1'b1;
        end else if (mv_valid) begin
          if (legal_s) begin
            row_d   = 3'(mv_idx_s / IDX_W'(N));
            col_d   = 3'(mv_idx_s % IDX_W'(N));
            sym_d   = mv_sym;
            state_d = S_WRITE;
          end else begin
            mv_err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        write_s = 1'b1;
        start_s = 1'b1;
        fill_d  = fill_q + CNT_W'(1);
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (scan_done_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        res_valid_d = 1'b1;
        // A completed run loses even when the same move fills the board
        if (lose_s) begin
          result_d    = (turn_q == TURN_P1) ? RES_P2 : RES_P1;
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end else if (fill_q == CNT_W'(CELLS)) begin
          result_d    = RES_TIE;
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end else begin
          turn_d  = (turn_q == TURN_P1) ? TURN_P2 : TURN_P1;
          state_d = S_IDLE;
        end
      end
      S_OVER: begin
        if (new_game) begin
          clear_s = 1'b1;
        end else begin
          state_d = S_OVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (clear_s) begin
      fill_d      = '0;
      turn_d      = TURN_P1;
      result_d    = RES_PLAY;
      game_over_d = 1'b0;
      state_d     = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Controller state and registered outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      sym_q       <= SYM_EMPTY;
      fill_q      <= '0;
      turn_q      <= TURN_P1;
      result_q    <= RES_PLAY;
      game_over_q <= 1'b0;
      mv_err_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sym_q       <= sym_d;
      fill_q      <= fill_d;
      turn_q      <= turn_d;
      result_q    <= result_d;
      game_over_q <= game_over_d;
      mv_err_q    <= mv_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Board storage: cleared on reset/new game, one cell written per accepted move
  always_ff @(posedge clock) begin
    if (!resetn || clear_s) begin
      for (int i = 0; i < CELLS; i++) begin
        board_q[i] <= SYM_EMPTY;
      end
    end else if (write_s) begin
      board_q[wr_idx_s] <= sym_q;
    end
  end

  line_walker #(
    .N     (N),
    .K     (K),
    .IDX_W (IDX_W)
  ) u_walker (
    .clock       (clock),
    .resetn      (resetn),
    .start_i     (start_s),
    .active_i    (active_s),
    .row_i       (row_q),
    .col_i       (col_q),
    .sym_i       (sym_q),
    .cell_i      (probe_cell_s),
    .probe_idx_o (probe_idx_s),
    .probe_on_o  (probe_on_s),
    .lose_o      (lose_s),
    .scan_done_o (scan_done_s)
  );

  assign mv_ready  = (state_q == S_IDLE);
  assign mv_err    = mv_err_q;
  assign res_valid = res_valid_q;
  assign game_over = game_over_q;
  assign result    = result_q;
  assign turn      = turn_q;
  assign fill_cnt  = fill_q;

endmodule
